// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan path.
package seg_pkg;

  localparam int NUM_DIGITS = 4;
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [3:0] AN_RESET = 4'b1110;

  typedef logic [1:0] scan_idx_t;

  // Packed display word for the default 4-bit digit width.
  typedef struct packed {
    logic        overflow;
    logic [3:0]  dp;
    logic [15:0] digits;
  } disp_word_t;

endpackage

// File: rtl/seg_scan_scheduler_tick_gen.sv
// Clock-enable prescaler: one-cycle tick every CLK_DIV cycles of clk.
module tick_gen #(
  parameter int CLK_DIV = 100000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] count_q, count_d;

  assign tick = (count_q == CW'(CLK_DIV - 1));

  always_comb begin
    count_d = count_q + 1'b1;
    if (tick) count_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/seg_scan_scheduler.sv
// Four-digit display multiplexer with frame-aligned double buffering and
// leading-zero blanking in front of a shared external segment decoder.
module seg_scan_scheduler
  import seg_pkg::*;
#(
  parameter int CLK_DIV     = 100000,
  parameter int DIGIT_WIDTH = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NUM_DIGITS*DIGIT_WIDTH-1:0] in_digits,
  input  logic                              in_overflow,
  input  logic [NUM_DIGITS-1:0]             in_dp,
  output logic [DIGIT_WIDTH-1:0]            decoder_in,
  input  logic [6:0]                        decoder_out,
  output logic                              overflow,
  output logic [6:0]                        seg,
  output logic                              dp,
  output logic [NUM_DIGITS-1:0]             an,
  output logic                              frame_done
);

  localparam int WW = NUM_DIGITS * DIGIT_WIDTH;

  logic tick;

  tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  scan_idx_t             idx_q, idx_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic [WW-1:0]         act_digits_q, act_digits_d;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
  logic                  act_ovf_q, act_ovf_d;

  logic [WW-1:0]         pend_digits_q, pend_digits_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic                  pend_ovf_q, pend_ovf_d;
  logic                  pend_full_q, pend_full_d;

  logic boundary;
  logic accept;

  assign boundary   = tick && (idx_q == scan_idx_t'(NUM_DIGITS - 1));
  assign accept     = in_valid && !pend_full_q;
  assign in_ready   = !pend_full_q;
  assign frame_done = boundary;

  always_comb begin
    idx_d = idx_q;
    an_d  = an_q;
    if (tick) begin
      idx_d = idx_q + 1'b1;
      an_d  = ~(NUM_DIGITS'(1) << idx_d);
    end
  end

  // The pending slot only drains at a frame boundary, so a frame never
  // shows a mix of two words. Accept and drain are mutually exclusive.
  always_comb begin
    act_digits_d  = act_digits_q;
    act_dp_d      = act_dp_q;
    act_ovf_d     = act_ovf_q;
    pend_digits_d = pend_digits_q;
    pend_dp_d     = pend_dp_q;
    pend_ovf_d    = pend_ovf_q;
    pend_full_d   = pend_full_q;
    if (boundary && pend_full_q) begin
      act_digits_d = pend_digits_q;
      act_dp_d     = pend_dp_q;
      act_ovf_d    = pend_ovf_q;
      pend_full_d  = 1'b0;
    end else if (accept) begin
      pend_digits_d = in_digits;
      pend_dp_d     = in_dp;
      pend_ovf_d    = in_overflow;
      pend_full_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q         <= '0;
      an_q          <= AN_RESET;
      act_digits_q  <= '0;
      act_dp_q      <= '0;
      act_ovf_q     <= 1'b0;
      pend_digits_q <= '0;
      pend_dp_q     <= '0;
      pend_ovf_q    <= 1'b0;
      pend_full_q   <= 1'b0;
    end else begin
      idx_q         <= idx_d;
      an_q          <= an_d;
      act_digits_q  <= act_digits_d;
      act_dp_q      <= act_dp_d;
      act_ovf_q     <= act_ovf_d;
      pend_digits_q <= pend_digits_d;
      pend_dp_q     <= pend_dp_d;
      pend_ovf_q    <= pend_ovf_d;
      pend_full_q   <= pend_full_d;
    end
  end

  // lead_zero[k]: digit k and all more-significant digits are zero.
  logic [NUM_DIGITS-1:1] lead_zero;
  logic [NUM_DIGITS-1:0] blank;

  assign blank[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_blank
      logic digit_zero;
      assign digit_zero = (act_digits_q[gi*DIGIT_WIDTH +: DIGIT_WIDTH] == '0);
      if (gi == NUM_DIGITS - 1) begin : g_top
        assign lead_zero[gi] = digit_zero;
      end else begin : g_mid
        assign lead_zero[gi] = digit_zero && lead_zero[gi+1];
      end
      assign blank[gi] = lead_zero[gi] && !act_ovf_q;
    end
  endgenerate

  assign an         = an_q;
  assign overflow   = act_ovf_q;
  assign decoder_in = act_digits_q[idx_q*DIGIT_WIDTH +: DIGIT_WIDTH];
  assign seg        = blank[idx_q] ? SEG_OFF : decoder_out;
  assign dp         = ~act_dp_q[idx_q];

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Randomised bench for seg_scan_scheduler against a frame-level reference model.
module tb_seg_scan_scheduler;

  localparam int CLK_DIV = 4;
  localparam int FRAME   = 4 * CLK_DIV;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_digits;
  logic        in_overflow;
  logic [3:0]  in_dp;
  logic [3:0]  decoder_in;
  logic [6:0]  decoder_out;
  logic        overflow;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  always #5 clk = ~clk;

  seg_scan_scheduler #(.CLK_DIV(CLK_DIV), .DIGIT_WIDTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_digits   (in_digits),
    .in_overflow (in_overflow),
    .in_dp       (in_dp),
    .decoder_in  (decoder_in),
    .decoder_out (decoder_out),
    .overflow    (overflow),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_done  (frame_done)
  );

  // External decoder stand-in: active-low gfedcba for 0..F.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'h0: seg_decode = 7'b1000000; 4'h1: seg_decode = 7'b1111001;
      4'h2: seg_decode = 7'b0100100; 4'h3: seg_decode = 7'b0110000;
      4'h4: seg_decode = 7'b0011001; 4'h5: seg_decode = 7'b0010010;
      4'h6: seg_decode = 7'b0000010; 4'h7: seg_decode = 7'b1111000;
      4'h8: seg_decode = 7'b0000000; 4'h9: seg_decode = 7'b0010000;
      4'hA: seg_decode = 7'b0001000; 4'hB: seg_decode = 7'b0000011;
      4'hC: seg_decode = 7'b1000110; 4'hD: seg_decode = 7'b0100001;
      4'hE: seg_decode = 7'b0000110; default: seg_decode = 7'b0001110;
    endcase
  endfunction

  assign decoder_out = seg_decode(decoder_in);

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic        ovf;
  } word_t;

  // Reference model: position within the frame plus the two word buffers.
  int    phase;
  word_t act_w, pend_w;
  bit    pend_full;
  bit    accepted;
  word_t directed_q[$];
  bit    did_mid_reset;
  bit    reset_this;

  function automatic word_t rand_word();
    word_t w;
    for (int k = 0; k < 4; k++)
      w.digits[k*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
    w.dp  = 4'($urandom);
    w.ovf = ($urandom_range(0, 3) == 0);
    return w;
  endfunction

  task automatic check_outputs();
    int          k;
    logic [3:0]  d;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    bit          blanked;
    k       = phase / CLK_DIV;
    d       = act_w.digits[k*4 +: 4];
    exp_an  = 4'b1111;
    exp_an[k] = 1'b0;
    blanked = (k != 0) && !act_w.ovf && ((act_w.digits >> (k*4)) == 16'd0);
    exp_seg = blanked ? 7'h7F : seg_decode(d);
    chk("an",         32'(an),         32'(exp_an));
    chk("decoder_in", 32'(decoder_in), 32'(d));
    chk("seg",        32'(seg),        32'(exp_seg));
    chk("dp",         32'(dp),         32'(!act_w.dp[k]));
    chk("overflow",   32'(overflow),   32'(act_w.ovf));
    chk("in_ready",   32'(in_ready),   32'(!pend_full));
    chk("frame_done", 32'(frame_done), 32'(phase == FRAME - 1));
  endtask

  initial begin
    word_t w;
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_digits   = '0;
    in_overflow = 1'b0;
    in_dp       = '0;
    phase       = 0;
    pend_full   = 0;
    accepted    = 0;
    did_mid_reset = 0;
    act_w       = '{digits: 16'h0, dp: 4'h0, ovf: 1'b0};
    pend_w      = act_w;

    directed_q.push_back('{digits: 16'h1234, dp: 4'b0010, ovf: 1'b0});
    directed_q.push_back('{digits: 16'h0007, dp: 4'b0000, ovf: 1'b0});
    directed_q.push_back('{digits: 16'h0007, dp: 4'b0000, ovf: 1'b1});
    directed_q.push_back('{digits: 16'h5555, dp: 4'b0000, ovf: 1'b0});
    directed_q.push_back('{digits: 16'h9999, dp: 4'b0000, ovf: 1'b0});
    directed_q.push_back('{digits: 16'hAF00, dp: 4'b1000, ovf: 1'b0});

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      accepted = 0;
      if (reset) begin
        phase     = 0;
        pend_full = 0;
        act_w     = '{digits: 16'h0, dp: 4'h0, ovf: 1'b0};
      end else begin
        if (phase == FRAME - 1 && pend_full) begin
          act_w     = pend_w;
          pend_full = 0;
        end else if (in_valid && !pend_full) begin
          pend_w    = '{digits: in_digits, dp: in_dp, ovf: in_overflow};
          pend_full = 1;
          accepted  = 1;
          $display("[TB] cycle %0d accept digits=%h dp=%b ovf=%0d",
                   cyc, in_digits, in_dp, in_overflow);
        end
        phase = (phase + 1) % FRAME;
      end

      @(negedge clk);
      check_outputs();

      // Idle first frames, then directed words, then random traffic.
      reset_this = (cyc < 2);
      if (!did_mid_reset && cyc > 300 && phase == 2*CLK_DIV + 1 && pend_full) begin
        reset_this    = 1;
        did_mid_reset = 1;
        $display("[TB] cycle %0d mid-frame reset with pending word %h", cyc, pend_w.digits);
      end
      if (cyc > 400 && $urandom_range(0, 499) == 0) reset_this = 1;
      reset = reset_this;

      if (reset_this || accepted) in_valid = 1'b0;
      if (!in_valid && !reset_this && cyc >= 2 + 2*FRAME) begin
        if (directed_q.size() > 0) begin
          w = directed_q.pop_front();
          in_valid = 1'b1;
        end else if (cyc > 200 && $urandom_range(0, 1) == 0) begin
          w = rand_word();
          in_valid = 1'b1;
        end
        if (in_valid) begin
          in_digits   = w.digits;
          in_dp       = w.dp;
          in_overflow = w.ovf;
        end
      end
    end

    tests_run++;
    if (!did_mid_reset) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset: got 0, expected 1 (mid-frame reset scenario never reached)");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/seg_scan_scheduler.md
# seg_scan_scheduler

Time-multiplexes the four-digit seven-segment display and the single shared digit decoder across four BCD digits. It runs from the system clock with an internal clock-enable prescaler, not a divided clock. It accepts new display words over a valid/ready handshake and swaps them in only at frame boundaries, so a frame never shows a mix of old and new digits. It sits between the binary-to-decimal conversion stage and the board display pins.

## Interface
- CLK_DIV, 100000: system-clock cycles per digit slot (1 kHz digit rate, 250 Hz frame rate at 100 MHz); legal range ≥ 2.
- DIGIT_WIDTH, 4: bits per digit.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  upstream has a display word.
- in_ready  out  1  pending buffer empty; transfer occurs on in_valid && in_ready at a rising edge of clk.
- in_digits  in  4*DIGIT_WIDTH  {digit3, digit2, digit1, digit0}, digit3 most significant.
- in_overflow  in  1  value out of range for the word.
- in_dp  in  4  per-digit decimal point, 1 = lit.
- decoder_in  out  DIGIT_WIDTH  digit presented to the shared decoder.
- decoder_out  in  7  decoder result, active-low segments, combinational from decoder_in.
- overflow  out  1  active word's overflow flag, routed to the decoder.
- seg  out  7  active-low segments.
- dp  out  1  active-low decimal point.
- an  out  4  active-low digit enables, exactly one low.
- frame_done  out  1  one-cycle pulse at each frame boundary.

## Operation
- Prescaler counts 0..CLK_DIV-1. tick = (count == CLK_DIV-1). Count wraps to 0 on tick.
- Scan index idx advances 0→1→2→3→0 on tick. an = ~(4'b0001 << idx), registered.
- decoder_in = active digit[idx]. seg = blank[idx] ? 7'h7F : decoder_out. dp = ~active_dp[idx].
- Leading-zero blanking: digit k (k = 3..1) is blanked when it and every more-significant digit are 0. Digit 0 is never blanked. Blanking is disabled while overflow = 1.
- Buffers: one pending slot (digits, overflow, dp, full flag) and one active set.
  - in_ready = !pending_full.
  - Accept loads the pending slot and sets full.
- Frame boundary: tick while idx == 3. If pending_full, the pending slot is copied to the active set and full is cleared. frame_done pulses in the same cycle.
- Accept and boundary in the same cycle are impossible: accept needs full = 0, and a boundary only copies when full = 1. If the boundary finds the slot empty, the active set is kept.
- in_valid without in_ready: the word is held off; the upstream must keep in_valid and in_digits stable (standard valid/ready).
- Digit values above 9 are passed to the decoder unchanged. The block never modifies digit values.

## Timing
- Reset values: prescaler 0, idx 0, an 4'b1110, active digits 0, active dp 0 (dp = 1), overflow 0, pending empty (in_ready = 1 from the first cycle after reset), frame_done 0. With digits 0, seg = decoder_out for 0.
- Reset mid-frame or with the pending slot full: all state returns to reset values on the next edge, and the pending word is discarded.
- Digit slot = CLK_DIV cycles. Frame = 4·CLK_DIV cycles.
- Accept-to-visible latency: from 1 cycle up to 4·CLK_DIV cycles. The new word first appears in the cycle after frame_done, on digit 0.
- seg and dp change in the same cycle as an (one combinational decoder path after the idx register).
- Maximum sustained throughput: one word per frame.

## Structure
- Package seg_pkg: NUM_DIGITS = 4, SEG_OFF = 7'h7F, AN_RESET = 4'b1110, a typedef for the 2-bit scan index, and a typedef for the packed display word {overflow, dp[3:0], digits}.
- Sub-module tick_gen: parameterised prescaler producing the one-cycle tick enable. It is reused by future blocks in place of chained clock dividers.
- The decoder stays outside this block. It is shared, and is driven only through decoder_in / decoder_out / overflow.

## Test plan
All scenarios use CLK_DIV = 4.
- Reset, then idle 16 cycles → an steps 1110, 1101, 1011, 0111, 1111 never appears. frame_done pulses at cycles 16, 32. in_ready = 1 throughout.
- Accept {1,2,3,4}, dp = 4'b0010 → in_ready low until the next frame_done. Next frame shows decoder_in 4,3,2,1 on idx 0..3 and dp low only on idx 1.
- Accept {0,0,0,7} → digits 3..1 have seg = 7'h7F and digit 0 shows 7. Repeat with overflow = 1 → no blanking, overflow = 1.
- Two back-to-back words {5,5,5,5} then {9,9,9,9} held valid → second accepted the cycle after the first frame boundary. No frame mixes 5s and 9s.
- Assert reset mid-frame (idx = 2) with the pending slot full → next cycle: an = 1110, active digits 0, in_ready = 1. The pending word never displays.
- in_digits = {A,F,0,0} → decoder_in receives A and F unmodified. Digits 1 and 0 are not blanked, because a nonzero more-significant digit exists.
